// File: rtl/expr_stim_pkg.sv
// Shared constants for the expression stimulus generator: vector layout, corner patterns, LFSR taps, FSM states.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package expr_stim_pkg;

  localparam int VEC_W = 60;

  // Field widths, MSB-first order a0,a1,a2,a3,a4,a5,b0,b1,b2,b3,b4,b5
  localparam int W_A0 = 4;
  localparam int W_A1 = 5;
  localparam int W_A2 = 6;
  localparam int W_A3 = 4;
  localparam int W_A4 = 5;
  localparam int W_A5 = 6;
  localparam int W_B0 = 4;
  localparam int W_B1 = 5;
  localparam int W_B2 = 6;
  localparam int W_B3 = 4;
  localparam int W_B4 = 5;
  localparam int W_B5 = 6;

  // Bit offset of each field's LSB inside the 60-bit vector
  localparam int OFF_A0 = 56;
  localparam int OFF_A1 = 51;
  localparam int OFF_A2 = 45;
  localparam int OFF_A3 = 41;
  localparam int OFF_A4 = 36;
  localparam int OFF_A5 = 30;
  localparam int OFF_B0 = 26;
  localparam int OFF_B1 = 21;
  localparam int OFF_B2 = 15;
  localparam int OFF_B3 = 11;
  localparam int OFF_B4 = 6;
  localparam int OFF_B5 = 0;

  // Corner patterns; the 4/5/6 field group repeats every 15 bits,
  // so SMIN/SMAX are one 15-bit group replicated four times.
  localparam logic [VEC_W-1:0] ZERO = '0;
  localparam logic [VEC_W-1:0] ONES = '1;
  localparam logic [VEC_W-1:0] SMIN = {4{15'h4420}};
  localparam logic [VEC_W-1:0] SMAX = {4{15'h3BDF}};

  // Fibonacci LFSR x^60 + x^59 + 1
  localparam int TAP_HI = 59;
  localparam int TAP_LO = 58;

  // FSM encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_CORNER = 2'd1;
  localparam state_t ST_RANDOM = 2'd2;
  localparam state_t ST_FINISH = 2'd3;

  function automatic logic [VEC_W-1:0] lfsr_next(input logic [VEC_W-1:0] s);
    return {s[VEC_W-2:0], s[TAP_HI] ^ s[TAP_LO]};
  endfunction

  function automatic logic [VEC_W-1:0] corner_vec(input logic [1:0] sel);
    logic [VEC_W-1:0] v;
    v = ZERO;
    case (sel)
      2'd0: v = ZERO;
      2'd1: v = ONES;
      2'd2: v = SMIN;
      2'd3: v = SMAX;
      default: v = ZERO;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/expr_lfsr60.sv
// 60-bit Fibonacci LFSR with synchronous seed load and single-step advance.
// Latency: new state visible the cycle after load/step.
// Backpressure: holds its state whenever step is low.
module expr_lfsr60
  import expr_stim_pkg::*;
#(
  parameter logic [VEC_W-1:0] INIT = 60'h1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [VEC_W-1:0] seed,
  input  logic             step,
  output logic [VEC_W-1:0] state
);

  // Load takes priority over step so a new run always starts from the seed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= INIT;
    end else if (load) begin
      state <= seed;
    end else if (step) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/expr_stim_gen.sv
// Stimulus generator for the expression stage: 4 corner vectors then LFSR vectors, cfg_count vectors per run.
// Latency: first vector valid the cycle after an accepted start; done pulses the cycle after the last transfer.
// Backpressure: valid/ready; vector and vec_idx hold while out_valid && !out_ready.
module expr_stim_gen
  import expr_stim_pkg::*;
#(
  parameter logic [VEC_W-1:0] SEED  = 60'h000_0000_0000_0001,
  parameter int               CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       a0,
  output logic [4:0]       a1,
  output logic [5:0]       a2,
  output logic [3:0]       a3,
  output logic [4:0]       a4,
  output logic [5:0]       a5,
  output logic [3:0]       b0,
  output logic [4:0]       b1,
  output logic [5:0]       b2,
  output logic [3:0]       b3,
  output logic [4:0]       b4,
  output logic [5:0]       b5,
  output logic [CNT_W-1:0] vec_idx,
  output logic             busy,
  output logic             done
);

  // An all-zero seed would lock the LFSR, so it is promoted to 1
  localparam logic [VEC_W-1:0] SEED_EFF = (SEED == '0) ? VEC_W'(1) : SEED;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [VEC_W-1:0] vec_q;
  logic [VEC_W-1:0] lfsr_state;
  logic             lfsr_load;
  logic             lfsr_step;
  logic             xfer;
  logic             last;

  assign xfer      = out_valid && out_ready;
  assign last      = (vec_idx == cnt_q - CNT_W'(1));
  assign lfsr_load = (state_q == ST_IDLE) && start;
  assign lfsr_step = xfer && (state_q == ST_RANDOM);

  expr_lfsr60 #(
    .INIT (SEED_EFF)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (lfsr_load),
    .seed  (SEED_EFF),
    .step  (lfsr_step),
    .state (lfsr_state)
  );

  // Run control: FSM, vector counter and the registered output vector
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      vec_q     <= ZERO;
      vec_idx   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            cnt_q   <= cfg_count;
            vec_idx <= '0;
            busy    <= 1'b1;
            if (cfg_count != '0) begin
              state_q   <= ST_CORNER;
              out_valid <= 1'b1;
              vec_q     <= corner_vec(2'd0);
            end else begin
              state_q <= ST_FINISH;
              done    <= 1'b1;
            end
          end
        end
        ST_CORNER: begin
          if (xfer) begin
            if (last) begin
              state_q   <= ST_FINISH;
              out_valid <= 1'b0;
              done      <= 1'b1;
            end else begin
              vec_idx <= vec_idx + CNT_W'(1);
              if (vec_idx[1:0] == 2'd3) begin
                // LFSR was loaded at start and has not stepped yet, so this is the seed
                state_q <= ST_RANDOM;
                vec_q   <= lfsr_state;
              end else begin
                vec_q <= corner_vec(vec_idx[1:0] + 2'd1);
              end
            end
          end
        end
        ST_RANDOM: begin
          if (xfer) begin
            if (last) begin
              state_q   <= ST_FINISH;
              out_valid <= 1'b0;
              done      <= 1'b1;
            end else begin
              // The LFSR steps on this same edge; present the value it steps to
              vec_idx <= vec_idx + CNT_W'(1);
              vec_q   <= lfsr_next(lfsr_state);
            end
          end
        end
        ST_FINISH: begin
          state_q <= ST_IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_q   <= ST_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

  assign a0 = vec_q[OFF_A0 +: W_A0];
  assign a1 = vec_q[OFF_A1 +: W_A1];
  assign a2 = vec_q[OFF_A2 +: W_A2];
  assign a3 = vec_q[OFF_A3 +: W_A3];
  assign a4 = vec_q[OFF_A4 +: W_A4];
  assign a5 = vec_q[OFF_A5 +: W_A5];
  assign b0 = vec_q[OFF_B0 +: W_B0];
  assign b1 = vec_q[OFF_B1 +: W_B1];
  assign b2 = vec_q[OFF_B2 +: W_B2];
  assign b3 = vec_q[OFF_B3 +: W_B3];
  assign b4 = vec_q[OFF_B4 +: W_B4];
  assign b5 = vec_q[OFF_B5 +: W_B5];

endmodule

// File: tb/tb_expr_stim_gen.sv
// Bench for expr_stim_gen: directed runs with a scoreboard queue drained by a transfer monitor.
// Latency: checks first-valid and done cycle against cycle counts from the accepted start.
// Backpressure: exercises constant, toggling and random out_ready; checks hold-stability on stalls.
module tb_expr_stim_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] cfg_count;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  a0, a3, b0, b3;
  logic [4:0]  a1, a4, b1, b4;
  logic [5:0]  a2, a5, b2, b5;
  logic [15:0] vec_idx;
  logic        busy;
  logic        done;

  logic [59:0] dut_v;
  assign dut_v = {a0, a1, a2, a3, a4, a5, b0, b1, b2, b3, b4, b5};

  expr_stim_gen dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .cfg_count (cfg_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a0 (a0), .a1 (a1), .a2 (a2), .a3 (a3), .a4 (a4), .a5 (a5),
    .b0 (b0), .b1 (b1), .b2 (b2), .b3 (b3), .b4 (b4), .b5 (b5),
    .vec_idx   (vec_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [59:0] v;
    logic [15:0] idx;
  } exp_t;

  exp_t expq[$];
  int   chk_cnt  = 0;
  int   err_cnt  = 0;
  int   done_cnt = 0;

  // Monitor state
  logic        stall = 1'b0;
  logic [59:0] held_v;
  logic [15:0] held_idx;
  exp_t        mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [59:0] model_step(input logic [59:0] s);
    return {s[58:0], s[59] ^ s[58]};
  endfunction

  // Corner vectors written field by field: a0..b5 widths 4,5,6 repeating
  function automatic logic [59:0] corner(input int i);
    logic [59:0] v;
    v = 60'h0;
    case (i)
      0: v = 60'h0;
      1: v = {60{1'b1}};
      2: v = {4'h8, 5'h10, 6'h20, 4'h8, 5'h10, 6'h20, 4'h8, 5'h10, 6'h20, 4'h8, 5'h10, 6'h20};
      3: v = {4'h7, 5'h0f, 6'h1f, 4'h7, 5'h0f, 6'h1f, 4'h7, 5'h0f, 6'h1f, 4'h7, 5'h0f, 6'h1f};
      default: v = 60'h0;
    endcase
    return v;
  endfunction

  task automatic push_run(input int cnt);
    logic [59:0] m;
    exp_t e;
    m = 60'h1;
    for (int i = 0; i < cnt; i++) begin
      e.idx = i[15:0];
      if (i < 4) begin
        e.v = corner(i);
      end else begin
        e.v = m;
        m   = model_step(m);
      end
      expq.push_back(e);
    end
  endtask

  // Transfer monitor: pops expected vectors, checks stall stability and done pulses
  initial begin
    forever begin
      @(negedge clk);
      if (stall && out_valid) begin
        check("hold_vec", 64'(dut_v), 64'(held_v));
        check("hold_idx", 64'(vec_idx), 64'(held_idx));
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          chk_cnt++;
          err_cnt++;
          $display("FAIL unexpected_xfer: got idx %0d vec %h expected no transfer", vec_idx, dut_v);
        end else begin
          mon_e = expq.pop_front();
          check("xfer_vec", 64'(dut_v), 64'(mon_e.v));
          check("xfer_idx", 64'(vec_idx), 64'(mon_e.idx));
        end
      end
      if (done) begin
        done_cnt++;
        check("done_busy", 64'(busy), 64'(1));
        check("done_valid", 64'(out_valid), 64'(0));
      end
      stall    = out_valid && !out_ready;
      held_v   = dut_v;
      held_idx = vec_idx;
    end
  end

  // mode: 0 ready=1, 1 ready toggling, 2 ready random, 3 ready=1 with start/cfg_count disturbance
  task automatic do_run(input int cnt, input int mode, input int exp_done_cyc);
    int cyc;
    int d0;
    bit got;
    push_run(cnt);
    d0  = done_cnt;
    got = 1'b0;
    cyc = 0;
    @(posedge clk); #1;
    start     = 1'b1;
    cfg_count = cnt[15:0];
    out_ready = (mode == 1) ? 1'b0 : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    while (!got && cyc < cnt * 4 + 20) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (mode == 3 && (cyc == 3 || cyc == 5)) begin
        start     = 1'b1;
        cfg_count = 16'd2;
      end
      if (cyc == 1) begin
        check("valid_latency", 64'(out_valid), 64'(cnt > 0));
        check("busy_latency", 64'(busy), 64'(1));
      end
      if (done) begin
        got = 1'b1;
        if (exp_done_cyc > 0) check("done_cycle", 64'(cyc), 64'(exp_done_cyc));
      end
      case (mode)
        1:       out_ready = ~out_ready;
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
    end
    if (!got) begin
      chk_cnt++;
      err_cnt++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected done for count %0d", cyc, cnt);
    end
    start = 1'b0;
    @(posedge clk); #1;
    check("busy_after_done", 64'(busy), 64'(0));
    check("done_pulses", 64'(done_cnt - d0), 64'(1));
    check("queue_drained", 64'(expq.size()), 64'(0));
    expq.delete();
  endtask

  task automatic reset_run();
    int cyc;
    int d0;
    push_run(5);
    d0  = done_cnt;
    cyc = 0;
    @(posedge clk); #1;
    start     = 1'b1;
    cfg_count = 16'd20;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!(out_valid && vec_idx == 16'd5) && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 40) begin
      chk_cnt++;
      err_cnt++;
      $display("FAIL reach_idx5: got idx %0d expected 5 within 40 cycles", vec_idx);
    end
    #2 reset = 1'b1;
    #1;
    check("abort_valid", 64'(out_valid), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_idx", 64'(vec_idx), 64'(0));
    check("abort_vec", 64'(dut_v), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_done", 64'(done_cnt - d0), 64'(0));
    check("abort_queue", 64'(expq.size()), 64'(0));
    expq.delete();
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    cfg_count = 16'd0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_idx", 64'(vec_idx), 64'(0));
    check("rst_vec", 64'(dut_v), 64'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    do_run(6, 0, 7);      // corners, then v=1, v=2
    do_run(3, 1, 0);      // truncated corners under toggling ready
    do_run(0, 0, 1);      // empty run: done only
    do_run(10, 3, 11);    // start and cfg_count disturbed mid-run
    reset_run();          // async abort at transfer 5 of 20
    do_run(5, 0, 6);      // fresh run after abort
    do_run(1000, 2, 0);   // long random-backpressure run vs LFSR model

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
